// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared defaults, state encoding and constants for the Collatz sweep block
package collatz_pkg;

    localparam int DEFAULT_BITS      = 32;
    localparam int DEFAULT_OLEN_BITS = 16;
    localparam int DEFAULT_CNT_BITS  = 16;

    // A step budget of zero lets each seed run until its length counter saturates.
    localparam int STEP_UNLIMITED = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_RECORD = 3'd3,
        ST_DONE   = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/collatz_step.sv
// rtl/collatz_step.sv - combinational single Collatz step with overflow and terminal detection
module collatz_step #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] n,
    output logic [BITS-1:0] next,
    output logic            overflow,
    output logic            is_one,
    output logic            is_zero
);

    localparam logic [BITS-1:0] ONE    = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS+1:0] ONE_WD = {{(BITS+1){1'b0}}, 1'b1};

    logic [BITS+1:0] triple;

    // 3n+1 as 2n + n + 1, two guard bits above BITS catch any carry out.
    assign triple   = {1'b0, n, 1'b0} + {2'b00, n} + ONE_WD;
    assign next     = n[0] ? triple[BITS-1:0] : {1'b0, n[BITS-1:1]};
    assign overflow = n[0] & (|triple[BITS+1:BITS]);
    assign is_one   = (n == ONE);
    assign is_zero  = (n == '0);

endmodule

// File: rtl/collatz_sweep_ctrl.sv
// rtl/collatz_sweep_ctrl.sv - sweeps a seed range through collatz_step, tracking the longest orbit
module collatz_sweep_ctrl
    import collatz_pkg::*;
#(
    parameter int BITS      = DEFAULT_BITS,
    parameter int OLEN_BITS = DEFAULT_OLEN_BITS,
    parameter int CNT_BITS  = DEFAULT_CNT_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BITS-1:0]      seed_base,
    input  logic [CNT_BITS-1:0]  seed_count,
    input  logic [OLEN_BITS-1:0] step_limit,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [BITS-1:0]      cur_seed,
    output logic [CNT_BITS-1:0]  seeds_done,
    output logic                 best_valid,
    output logic [BITS-1:0]      best_seed,
    output logic [OLEN_BITS-1:0] best_len,
    output logic                 overflow_seen,
    output logic                 timeout_seen
);

    localparam logic [OLEN_BITS-1:0] LIM_NONE = OLEN_BITS'(STEP_UNLIMITED);
    localparam logic [OLEN_BITS-1:0] LEN_ONE  = {{(OLEN_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0]      SEED_ONE = {{(BITS-1){1'b0}}, 1'b1};

    sweep_state_t         state_q, state_d;
    logic [CNT_BITS-1:0]  seed_count_q, seed_count_d;
    logic [OLEN_BITS-1:0] step_limit_q, step_limit_d;
    logic [BITS-1:0]      cur_seed_q, cur_seed_d;
    logic [BITS-1:0]      n_q, n_d;
    logic [OLEN_BITS-1:0] len_q, len_d;
    logic                 cand_q, cand_d;
    logic [CNT_BITS-1:0]  seeds_done_q, seeds_done_d;
    logic                 best_valid_q, best_valid_d;
    logic [BITS-1:0]      best_seed_q, best_seed_d;
    logic [OLEN_BITS-1:0] best_len_q, best_len_d;
    logic                 ovf_q, ovf_d;
    logic                 tmo_q, tmo_d;

    logic [BITS-1:0] step_next;
    logic            step_ovf;
    logic            step_one;
    logic            step_zero;
    logic            budget_hit;

    collatz_step #(.BITS(BITS)) u_step (
        .n        (n_q),
        .next     (step_next),
        .overflow (step_ovf),
        .is_one   (step_one),
        .is_zero  (step_zero)
    );

    // An unlimited budget still stops at the saturation point so len never wraps.
    assign budget_hit = (step_limit_q != LIM_NONE) ? (len_q == step_limit_q)
                                                   : (len_q == '1);

    always_comb begin
        state_d      = state_q;
        seed_count_d = seed_count_q;
        step_limit_d = step_limit_q;
        cur_seed_d   = cur_seed_q;
        n_d          = n_q;
        len_d        = len_q;
        cand_d       = cand_q;
        seeds_done_d = seeds_done_q;
        best_valid_d = best_valid_q;
        best_seed_d  = best_seed_q;
        best_len_d   = best_len_q;
        ovf_d        = ovf_q;
        tmo_d        = tmo_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    seed_count_d = seed_count;
                    step_limit_d = step_limit;
                    cur_seed_d   = seed_base;
                    seeds_done_d = '0;
                    best_valid_d = 1'b0;
                    best_seed_d  = '0;
                    best_len_d   = '0;
                    ovf_d        = 1'b0;
                    tmo_d        = 1'b0;
                    state_d      = (seed_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                n_d     = cur_seed_q;
                len_d   = '0;
                cand_d  = 1'b0;
                state_d = abort ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (step_one) begin
                    cand_d  = 1'b1;
                    state_d = ST_RECORD;
                end else if (step_zero) begin
                    state_d = ST_RECORD;
                end else if (budget_hit) begin
                    tmo_d   = 1'b1;
                    state_d = ST_RECORD;
                end else if (step_ovf) begin
                    ovf_d   = 1'b1;
                    state_d = ST_RECORD;
                end else begin
                    n_d   = step_next;
                    len_d = len_q + LEN_ONE;
                end
            end
            ST_RECORD: begin
                // Strict greater-than keeps the earlier seed on a tie.
                if (cand_q && (!best_valid_q || (len_q > best_len_q))) begin
                    best_valid_d = 1'b1;
                    best_seed_d  = cur_seed_q;
                    best_len_d   = len_q;
                end
                seeds_done_d = seeds_done_q + CNT_ONE;
                if (abort || (seeds_done_d == seed_count_q)) begin
                    state_d = ST_DONE;
                end else begin
                    cur_seed_d = cur_seed_q + SEED_ONE;
                    state_d    = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            seed_count_q <= '0;
            step_limit_q <= '0;
            cur_seed_q   <= '0;
            n_q          <= '0;
            len_q        <= '0;
            cand_q       <= 1'b0;
            seeds_done_q <= '0;
            best_valid_q <= 1'b0;
            best_seed_q  <= '0;
            best_len_q   <= '0;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_count_q <= seed_count_d;
            step_limit_q <= step_limit_d;
            cur_seed_q   <= cur_seed_d;
            n_q          <= n_d;
            len_q        <= len_d;
            cand_q       <= cand_d;
            seeds_done_q <= seeds_done_d;
            best_valid_q <= best_valid_d;
            best_seed_q  <= best_seed_d;
            best_len_q   <= best_len_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
        end
    end

    assign busy          = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_RECORD);
    assign done          = (state_q == ST_DONE);
    assign cur_seed      = cur_seed_q;
    assign seeds_done    = seeds_done_q;
    assign best_valid    = best_valid_q;
    assign best_seed     = best_seed_q;
    assign best_len      = best_len_q;
    assign overflow_seen = ovf_q;
    assign timeout_seen  = tmo_q;

endmodule

// File: doc/collatz_sweep_ctrl.md
# collatz_sweep_ctrl

Sequencing controller that sweeps a contiguous range of Collatz seeds through a single-step datapath, one step per clock. It reports the seed with the longest orbit plus overflow and timeout flags. It sits between the chip's I/O front end and the step datapath: the front end programs the seed range and step budget, pulses `start`, and reads the results once `done` rises.

## Interface
- `BITS`, 32, iterate/seed width
- `OLEN_BITS`, 16, orbit-length and step-limit width
- `CNT_BITS`, 16, seed-count width

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  single-cycle pulse; accepted only in IDLE or DONE
- `seed_base`  in  BITS  first seed, sampled with an accepted `start`
- `seed_count`  in  CNT_BITS  number of seeds, sampled with `start`
- `step_limit`  in  OLEN_BITS  per-seed step budget, sampled with `start`; 0 means unlimited
- `abort`  in  1  level; ends the sweep early
- `busy`  out  1  high in LOAD, RUN and RECORD
- `done`  out  1  high in DONE; held until the next accepted `start`
- `cur_seed`  out  BITS  seed currently being processed
- `seeds_done`  out  CNT_BITS  seeds finished, including abandoned seeds
- `best_valid`  out  1  at least one seed reached 1
- `best_seed`  out  BITS  seed with the longest orbit
- `best_len`  out  OLEN_BITS  orbit length of `best_seed`
- `overflow_seen`  out  1  at least one seed overflowed BITS
- `timeout_seen`  out  1  at least one seed hit `step_limit`

## Operation
- States: IDLE, LOAD, RUN, RECORD, DONE. Reset enters IDLE.
- All outputs reset to 0.
- **IDLE/DONE + `start`** → LOAD.
  - Latch the three inputs.
  - `cur_seed` = `seed_base`.
  - Clear `seeds_done`, `best_*`, and both flags.
  - If `seed_count` = 0, go to DONE instead.
- **LOAD** (1 cycle): `n` = `cur_seed`, `len` = 0 → RUN.
- **RUN**, evaluated each cycle in this priority order:
  - `n` = 1 → RECORD; seed is a candidate.
  - `n` = 0 → RECORD; seed is abandoned, no flag set.
  - `step_limit` ≠ 0 and `len` = `step_limit` → RECORD; set `timeout_seen`, seed abandoned.
  - Step overflow → RECORD; set `overflow_seen`, seed abandoned.
  - Otherwise: `n` = next, `len` += 1.
- **Step arithmetic**
  - Even `n`: next = `n` >> 1.
  - Odd `n`: next = 3n+1, computed at BITS+2 bits.
  - Any nonzero bit above BITS is an overflow.
- **RECORD** (1 cycle):
  - Candidate replaces best if `best_valid` = 0 or `len` > `best_len`. Ties keep the earlier seed.
  - `seeds_done` += 1.
  - If `seeds_done` reaches `seed_count` → DONE.
  - Otherwise `cur_seed` += 1 (mod 2^BITS) → LOAD.
- **`abort`** in LOAD/RUN/RECORD → DONE on the next edge.
  - An abort during RECORD still commits that seed's result.
  - All other results hold. `abort` is ignored in IDLE and DONE.
- `start` while busy is ignored.
- `start` and `abort` together in IDLE/DONE: `start` wins.
- `len` never wraps: seeds beyond 2^OLEN_BITS−1 steps need `step_limit` ≠ 0. With `step_limit` = 0, a saturating `len` counts as a timeout.

## Timing
- Seed with orbit length L: exactly L+3 cycles (LOAD, L+1 in RUN, RECORD).
- A sweep takes Σ(L_i + 3) cycles, where L_i is the step count at exit for each seed.
- `done` rises on the edge after the final RECORD.
  - For a single seed: the (L+3)th rising edge after the edge that sampled `start`.
- `busy` rises on the edge that samples `start` and falls on the edge `done` rises. They are never high together.
- Result outputs change only on the RECORD edge and the `start` edge. They are stable otherwise.
- Reset mid-sweep: outputs go to 0 asynchronously; the sweep is discarded.

## Structure
- Package `collatz_pkg` holds:
  - default `BITS`, `OLEN_BITS`, `CNT_BITS`
  - state enum `sweep_state_t`
  - `STEP_UNLIMITED` = 0
- Sub-module `collatz_step` is purely combinational: input `n`; outputs `next`, `overflow`, `is_one`, `is_zero`.
  - It is the only arithmetic in the block, so it can be reused or pipelined later.

## Test plan
- `seed_base`=27, count=1, limit=0 → `best_seed`=27, `best_len`=111, `done` on the 114th edge after `start`, `busy` low at the same edge.
- `seed_base`=1, count=10 → `best_seed`=9, `best_len`=19, `seeds_done`=10, no flags, total 97 cycles.
- `seed_base`=27, count=1, limit=50 → `timeout_seen`=1, `best_valid`=0, `done` after 53 cycles.
- `BITS`=8, `seed_base`=27 → overflow at 107→322 → `overflow_seen`=1, `best_valid`=0. Then `BITS`=8, `seed_base`=255, count=2 → 255 overflows, next seed wraps to 0 and is abandoned, `seeds_done`=2.
- `seed_count`=0 → `done` one edge after `start`, `busy` never high.
- Seeds 1..10 with `abort` raised mid-RUN of seed 7 → DONE next edge, `seeds_done`=6, `best_seed`=6, `best_len`=8. A second sweep started on the same seeds, with async `reset` pulsed mid-RUN → all outputs 0 immediately, IDLE afterwards.
